// File: rtl/axis_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// axis_pkt_rr_arbiter : packet-locked round-robin N:1 AXI-Stream arbiter
// Rev 1.0
// ============================================================================
module axis_pkt_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_IN       = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_IN*DATA_WIDTH-1:0]   in_TDATA,
  input  logic [N_IN-1:0]              in_TVALID,
  output logic [N_IN-1:0]              in_TREADY,
  input  logic [N_IN*DATA_WIDTH/8-1:0] in_TKEEP,
  input  logic [N_IN-1:0]              in_TDEST,
  input  logic [N_IN-1:0]              in_TID,
  input  logic [N_IN-1:0]              in_TLAST,
  output logic [DATA_WIDTH-1:0]        out_TDATA,
  output logic                         out_TVALID,
  input  logic                         out_TREADY,
  output logic [DATA_WIDTH/8-1:0]      out_TKEEP,
  output logic                         out_TDEST,
  output logic                         out_TID,
  output logic                         out_TLAST,
  output logic                         grant_vld,
  output logic [$clog2(N_IN)-1:0]      grant_idx,
  output logic [N_IN*CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(N_IN);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_IN];
  logic [CNT_WIDTH-1:0] cnt_d [N_IN];

  logic                 any_vld;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W:0]       cand;
  logic                 g_vld;
  logic                 g_last;
  logic                 beat_acc;
  logic                 last_acc;

  // Scan downward so the lowest offset from the rr pointer wins.
  always_comb begin
    any_vld = 1'b0;
    pick    = rr_q;
    cand    = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_IN)) begin
        cand = cand - (IDX_W+1)'(N_IN);
      end
      if (in_TVALID[cand[IDX_W-1:0]]) begin
        any_vld = 1'b1;
        pick    = cand[IDX_W-1:0];
      end
    end
  end

  assign g_vld    = in_TVALID[grant_q];
  assign g_last   = in_TLAST[grant_q];
  assign beat_acc = (state_q == S_BUSY) && g_vld && out_TREADY;
  assign last_acc = beat_acc && g_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_vld)  state_d = S_BUSY;
      S_BUSY: if (last_acc) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if ((state_q == S_IDLE) && any_vld) begin
      grant_d = pick;
    end
    if (last_acc) begin
      rr_d = (grant_q == IDX_W'(N_IN - 1)) ? '0 : grant_q + 1'b1;
      cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mux is purely combinational on the locked grant: zero added latency.
  always_comb begin
    in_TREADY  = '0;
    out_TVALID = 1'b0;
    if (state_q == S_BUSY) begin
      in_TREADY[grant_q] = out_TREADY;
      out_TVALID         = g_vld;
    end
    out_TDATA = in_TDATA[grant_q*DATA_WIDTH +: DATA_WIDTH];
    out_TKEEP = in_TKEEP[grant_q*KEEP_W +: KEEP_W];
    out_TDEST = in_TDEST[grant_q];
    out_TID   = in_TID[grant_q];
    out_TLAST = g_last;
  end

  assign grant_vld = (state_q == S_BUSY);
  assign grant_idx = grant_q;

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_cnt
      assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI-Stream output between N_IN AXI-Stream inputs.
- A grant is locked from the first accepted beat of a packet through its TLAST beat, so packets are never interleaved.
- Sits upstream of the stream-stats tap and the network egress.
- Exports per-input granted-packet counts and the current grant for debug/telemetry.

Parameters:
- DATA_WIDTH, 32, TDATA width per port (multiple of 8).
- N_IN, 4, number of input streams (2..16).
- CNT_WIDTH, 32, width of each per-input packet counter.

Ports:
- clk  input  1  single clock.
- rstn  input  1  reset, asynchronous assert, active-low (deassert is synchronous to clk upstream).
- in_TDATA  input  N_IN*DATA_WIDTH  input i data at [i*DATA_WIDTH +: DATA_WIDTH].
- in_TVALID  input  N_IN  per-input valid.
- in_TREADY  output  N_IN  per-input ready.
- in_TKEEP  input  N_IN*DATA_WIDTH/8  per-input keep.
- in_TDEST  input  N_IN  per-input dest (1 bit each).
- in_TID  input  N_IN  per-input id (1 bit each).
- in_TLAST  input  N_IN  per-input last.
- out_TDATA  output  DATA_WIDTH  arbitrated data.
- out_TVALID  output  1  arbitrated valid.
- out_TREADY  input  1  downstream ready.
- out_TKEEP  output  DATA_WIDTH/8  arbitrated keep.
- out_TDEST  output  1  arbitrated dest.
- out_TID  output  1  arbitrated id.
- out_TLAST  output  1  arbitrated last.
- grant_vld  output  1  high while an input is granted (state BUSY).
- grant_idx  output  clog2(N_IN)  index of granted input; holds its last value when grant_vld=0.
- pkt_cnt  output  N_IN*CNT_WIDTH  per-input count of completed (TLAST-accepted) packets.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, grant_vld=0, grant_idx=0, rr pointer=0, all pkt_cnt=0.
  - out_TVALID=0 and in_TREADY=0 immediately.
  - A packet in flight at reset is abandoned; no flush, no count.
- State IDLE:
  - out_TVALID=0, all in_TREADY=0.
  - If any in_TVALID is set, select the first valid input searching from the rr pointer upward, wrapping modulo N_IN.
  - Register grant_idx, go to BUSY next cycle.
  - The arbitration cycle is always one bubble cycle; no beat is transferred in IDLE.
- State BUSY (grant g):
  - out_* = in_*[g] combinationally, zero added latency.
  - in_TREADY[g]=out_TREADY; in_TREADY[j≠g]=0.
  - Beat accepted when in_TVALID[g] && out_TREADY.
  - On an accepted beat with in_TLAST[g]=1:
    - pkt_cnt[g] increments by 1;
    - rr pointer = (g+1) mod N_IN;
    - state returns to IDLE next cycle.
  - Valid deassertion mid-packet (gaps) does not release the grant; the grant is held indefinitely until TLAST.
  - A grant may be issued on a valid that is later dropped; the block then waits in BUSY.
- Fairness: with all inputs continuously valid, the grant order is 0,1,…,N_IN-1,0,…; each packet costs its beat count plus 1 bubble cycle.
- Simultaneous events: a TLAST accept and new valids in the same cycle produce no same-cycle regrant; the next grant is decided in the following IDLE cycle.
- Counters: pkt_cnt wraps modulo 2^CNT_WIDTH with no saturation.
- Single-beat packets (TVALID with TLAST on the first beat) take 2 cycles: IDLE then BUSY.
- AXI rules:
  - out_TVALID never depends on out_TREADY.
  - Output signals are stable while out_TVALID=1 && out_TREADY=0, because the inputs are held per AXI and the grant is fixed in BUSY.

Test Plan:
- Reset, then in_TVALID=4'b0100 with a 3-beat packet, out_TREADY=1 -> IDLE 1 cycle, grant_idx=2, 3 beats out on consecutive cycles, pkt_cnt[2]=1, rr pointer=3.
- All 4 inputs valid with 2-beat packets, out_TREADY=1 -> grant order 0,1,2,3,0; 3 cycles per packet; after 8 packets every pkt_cnt=2.
- Input 1 granted; input 1 drops TVALID for 5 cycles mid-packet while input 3 is valid -> in_TREADY[3]=0 throughout, grant_idx stays 1, output resumes on input 1 with no interleave.
- out_TREADY toggled 1,0,0,1 during a 4-beat packet -> data held stable while stalled, exactly 4 beats transferred, pkt_cnt increments once at the TLAST accept.
- rstn pulsed low asynchronously mid-packet on input 0 -> out_TVALID=0 and in_TREADY=0 without waiting for a clk edge, pkt_cnt all 0; after release, input 0 is re-granted from pointer 0.
- CNT_WIDTH=4; send 17 single-beat packets on input 0 only -> pkt_cnt[0]=1 (wrap), 34 cycles total.
